updown_score_counter: RTL and testbench
=======================================

UPDOWN_SCORE_COUNTER -- requirements
Module: updown_score_counter

Interface
REQ-001 Parameter BW, default 7, SHALL set the counter_val_o width in bits.
REQ-002 Parameter MAX_VAL, default 99, SHALL set the upper count limit; MAX_VAL < 2**BW.
REQ-003 Parameter WRAP, default 0, SHALL select the limit mode: 0 = saturate, 1 = wrap-around.
REQ-004 Parameter DEB_CYCLES, default 16, SHALL set the debounce stability length in clk_i cycles; it is used only when SCORE_DEBOUNCE_EN is defined.
REQ-005 clk_i  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-006 rst_i  input  1  SHALL be the reset, synchronous and active-high.
REQ-007 up_i  input  1  SHALL be the count-up request, asynchronous button level.
REQ-008 down_i  input  1  SHALL be the count-down request, asynchronous button level.
REQ-009 clear_i  input  1  SHALL be the synchronous clear, already in the clk_i domain; active-high.
REQ-010 counter_val_o  output  BW  SHALL be the registered score value, range 0..MAX_VAL.
REQ-011 at_max_o  output  1  SHALL be registered high exactly when counter_val_o == MAX_VAL.
REQ-012 at_min_o  output  1  SHALL be registered high exactly when counter_val_o == 0.

Function
REQ-013 up_i and down_i SHALL each pass through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~prev).
REQ-014 One detected edge SHALL produce exactly one count event, whatever the hold time.
REQ-015 Without debounce, a count SHALL be visible after the 3rd rising clk_i edge at which the input is high, counting the first sampling edge as edge 1.
REQ-016 An up event with counter < MAX_VAL SHALL increment by 1.
REQ-017 An up event at MAX_VAL SHALL hold at MAX_VAL when WRAP=0 and load 0 when WRAP=1.
REQ-018 A down event with counter > 0 SHALL decrement by 1.
REQ-019 A down event at 0 SHALL hold at 0 when WRAP=0 and load MAX_VAL when WRAP=1.
REQ-020 Up and down events in the same cycle SHALL leave the counter unchanged.
REQ-021 clear_i high at a rising edge SHALL load 0 and discard any event in that cycle; clear_i outranks up/down.
REQ-022 at_max_o and at_min_o SHALL update in the same cycle as counter_val_o; they are never combinationally derived from inputs.
REQ-023 Arithmetic SHALL be BW-bit unsigned, with no intermediate overflow beyond MAX_VAL or below 0.

Reset
REQ-024 rst_i high at a rising edge SHALL set counter_val_o=0, at_min_o=1, at_max_o=0, and clear debounce counters to 0.
REQ-025 Synchronizer and edge-history flops SHALL reset to 1, so an input held high through reset release produces no count until it is seen low and then high again.
REQ-026 rst_i SHALL outrank clear_i and all events; reset asserted mid-debounce SHALL abort the pending event.

Configuration
REQ-027 Macro SCORE_DEBOUNCE_EN, when defined, SHALL insert a per-input filter between synchronizer and edge detector.
REQ-028 With SCORE_DEBOUNCE_EN, the filtered level SHALL change only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any glitch restarts the count; latency grows by DEB_CYCLES cycles.
REQ-029 Without SCORE_DEBOUNCE_EN, there SHALL be no filter logic, DEB_CYCLES SHALL be ignored, and REQ-015 latency applies.

Verification
REQ-030 Reset, then 5 up pulses (each 4 cycles high, 4 low) -> counter_val_o=5, at_min_o=0.
REQ-031 WRAP=0, 101 up pulses from 0 -> counter_val_o=99, at_max_o=1; then 1 down pulse -> 98.
REQ-032 WRAP=1, counter at 99, 1 up pulse -> 0, at_min_o=1; 1 down pulse -> 99.
REQ-033 Counter at 10, up_i and down_i rise in the same cycle -> counter stays 10; clear_i together with an up edge -> 0.
REQ-034 up_i held high across rst_i deassertion for 50 cycles -> counter stays 0; release and re-press -> 1.
REQ-035 SCORE_DEBOUNCE_EN defined, DEB_CYCLES=16: an up_i glitch 10 cycles long -> no count; an up_i pulse 20 cycles long -> exactly 1 count.

Source files
------------

// File: rtl/updown_score_counter.sv
// updown_score_counter
// Two-button score counter (up / down) with synchronous clear, saturating or
// wrapping at MAX_VAL. Button inputs are asynchronous levels; each goes
// through a 2-flop synchronizer and a rising-edge detector so that one press
// yields exactly one count event regardless of how long it is held.
//
// Optional feature: define SCORE_DEBOUNCE_EN to insert a per-button stability
// filter (DEB_CYCLES consecutive cycles) between synchronizer and edge
// detector. Without the macro no filter logic exists and DEB_CYCLES is unused.
//
// Output timing: counter_val_o, at_max_o and at_min_o are all registered and
// change together. Without the filter a press becomes visible after the 3rd
// rising clk_i edge that samples the button high.
module updown_score_counter #(
  parameter int BW         = 7,
  parameter int MAX_VAL    = 99,
  parameter int WRAP       = 0,
  parameter int DEB_CYCLES = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          up_i,
  input  logic          down_i,
  input  logic          clear_i,
  output logic [BW-1:0] counter_val_o,
  output logic          at_max_o,
  output logic          at_min_o
);

  localparam logic [BW-1:0] MAX_V = BW'(MAX_VAL);

  // Bit 0 carries the up button, bit 1 the down button, through the whole
  // input pipeline.
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] level;     // level fed to the edge detector
  logic [1:0] prev;      // edge-detector history
  logic [1:0] edge_ev;   // one-cycle count events

  logic [BW-1:0] counter;
  logic [BW-1:0] nxt;

  // Two-flop synchronizer; resets high so a button held through reset
  // release must be seen low before it can count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {down_i, up_i};
      sync2 <= sync1;
    end
  end

`ifdef SCORE_DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [1:0]    filt;
  logic [DW-1:0] deb_cnt [2];

  // Stability filter: the filtered level follows the synchronized level only
  // after they have disagreed for DEB_CYCLES consecutive cycles; any cycle
  // of agreement restarts the run.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt <= 2'b11;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            filt[i]    <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  // Edge-detector history register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev <= 2'b11;
    end else begin
      prev <= level;
    end
  end

  assign edge_ev = level & ~prev;

  // Next score: clear wins, simultaneous up+down cancel, limits handled by
  // comparison before arithmetic so no intermediate value leaves 0..MAX_VAL.
  always_comb begin
    nxt = counter;
    if (clear_i) begin
      nxt = '0;
    end else if (edge_ev[0] && !edge_ev[1]) begin
      if (counter < MAX_V)  nxt = counter + BW'(1);
      else if (WRAP != 0)   nxt = '0;
      else                  nxt = MAX_V;
    end else if (edge_ev[1] && !edge_ev[0]) begin
      if (counter > '0)     nxt = counter - BW'(1);
      else if (WRAP != 0)   nxt = MAX_V;
      else                  nxt = '0;
    end
  end

  // Score and limit flags register together from the same next value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      counter  <= '0;
      at_max_o <= 1'b0;
      at_min_o <= 1'b1;
    end else begin
      counter  <= nxt;
      at_max_o <= (nxt == MAX_V);
      at_min_o <= (nxt == '0);
    end
  end

  assign counter_val_o = counter;

endmodule

// File: tb/tb_updown_score_counter.sv
// tb_updown_score_counter
// Drives two instances (saturating and wrapping) with identical stimulus.
// Each driver task updates an arithmetic reference score per instance and
// pushes the expected {value, at_max, at_min} pair into exp_q once the
// response has had time to settle; a separate monitor pops and compares.
// Define SCORE_DEBOUNCE_EN for both files to exercise the filter build.
module tb_updown_score_counter;

  localparam int BW  = 7;
  localparam int MAX = 99;
  localparam int DEB = 16;
`ifdef SCORE_DEBOUNCE_EN
  localparam int LAT = DEB;
`else
  localparam int LAT = 0;
`endif
  localparam int EW = BW + 2;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          up_i = 1'b0;
  logic          down_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [BW-1:0] val_s, val_w;
  logic          max_s, max_w, min_s, min_w;

  logic [2*EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int score_s = 0;
  int score_w = 0;

  updown_score_counter #(.BW(BW), .MAX_VAL(MAX), .WRAP(0), .DEB_CYCLES(DEB)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .up_i(up_i), .down_i(down_i), .clear_i(clear_i),
    .counter_val_o(val_s), .at_max_o(max_s), .at_min_o(min_s));

  updown_score_counter #(.BW(BW), .MAX_VAL(MAX), .WRAP(1), .DEB_CYCLES(DEB)) dut_wrap (
    .clk_i(clk), .rst_i(rst_i), .up_i(up_i), .down_i(down_i), .clear_i(clear_i),
    .counter_val_o(val_w), .at_max_o(max_w), .at_min_o(min_w));

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, queued=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int model_step(int s, bit u, bit d, bit wrap);
    if (u && !d) return (s < MAX) ? s + 1 : (wrap ? 0 : MAX);
    if (d && !u) return (s > 0) ? s - 1 : (wrap ? MAX : 0);
    return s;
  endfunction

  function automatic logic [EW-1:0] pack(int s);
    logic [BW-1:0] v;
    v = BW'(s);
    return {v, (s == MAX), (s == 0)};
  endfunction

  task automatic push_expected();
    exp_q.push_back({pack(score_s), pack(score_w)});
    @(negedge clk);
  endtask

  // ---------------- driver tasks (inputs change on negedge) ----------------
  task automatic press(bit u, bit d, int hold, int low);
    @(negedge clk);
    up_i = u;
    down_i = d;
    repeat (hold) @(negedge clk);
    up_i = 1'b0;
    down_i = 1'b0;
    repeat (low) @(negedge clk);
    score_s = model_step(score_s, u, d, 1'b0);
    score_w = model_step(score_w, u, d, 1'b1);
    push_expected();
  endtask

  task automatic pulse_std(bit u, bit d);
    press(u, d, LAT + 4, LAT + 4);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    score_s = 0;
    score_w = 0;
    push_expected();
  endtask

  task automatic do_reset(bit hold_up);
    @(negedge clk);
    rst_i = 1'b1;
    up_i = hold_up;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    score_s = 0;
    score_w = 0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [2*EW-1:0] exp;
      logic [2*EW-1:0] act;
      exp = exp_q.pop_front();
      act = {val_s, max_s, min_s, val_w, max_w, min_w};
      checks++;
      if (act[2*EW-1:EW] !== exp[2*EW-1:EW]) begin
        errors++;
        $display("FAIL sat_check#%0d: got val=%0d max=%0b min=%0b, need val=%0d max=%0b min=%0b",
                 checks, act[2*EW-1:EW+2], act[EW+1], act[EW],
                 exp[2*EW-1:EW+2], exp[EW+1], exp[EW]);
      end
      if (act[EW-1:0] !== exp[EW-1:0]) begin
        errors++;
        $display("FAIL wrap_check#%0d: got val=%0d max=%0b min=%0b, need val=%0d max=%0b min=%0b",
                 checks, act[EW-1:2], act[1], act[0], exp[EW-1:2], exp[1], exp[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int hold;
    int low;
    int op;

    // Reset state.
    do_reset(1'b0);
    push_expected();

    // Five ordinary up presses.
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 4 + LAT, 4 + LAT);

    // Saturation / wrap at the top: 101 ups from 0, then one down.
    do_clear();
    for (int i = 0; i < 101; i++) pulse_std(1'b1, 1'b0);
    pulse_std(1'b0, 1'b1);

    // Bottom boundary: one down from 0, then one up.
    do_clear();
    pulse_std(1'b0, 1'b1);
    pulse_std(1'b1, 1'b0);

    // Score 10, then both buttons rise together: no change.
    do_clear();
    for (int i = 0; i < 10; i++) pulse_std(1'b1, 1'b0);
    pulse_std(1'b1, 1'b1);

    // Clear in the same cycle as the up event: clear wins.
    @(negedge clk);
    up_i = 1'b1;
    repeat (2 + LAT) @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    repeat (3) @(negedge clk);
    up_i = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    score_s = 0;
    score_w = 0;
    push_expected();

    // Button held high through reset release: no count; re-press counts.
    pulse_std(1'b1, 1'b0);
    do_reset(1'b1);
    repeat (50) @(negedge clk);
    push_expected();
    up_i = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    pulse_std(1'b1, 1'b0);

`ifdef SCORE_DEBOUNCE_EN
    // Short glitch is filtered; a long press counts once.
    @(negedge clk);
    up_i = 1'b1;
    repeat (10) @(negedge clk);
    up_i = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    push_expected();
    press(1'b1, 1'b0, 20, DEB + 6);
`endif

    // Randomized operations.
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      hold = LAT + $urandom_range(2, 6);
      low = LAT + $urandom_range(4, 7);
      if (op < 4)       press(1'b1, 1'b0, hold, low);
      else if (op < 8)  press(1'b0, 1'b1, hold, low);
      else if (op < 9)  press(1'b1, 1'b1, hold, low);
      else              do_clear();
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, need 0", exp_q.size());
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
